// File: rtl/nn_pkg.sv
// Shared types, default sizes and the word-arithmetic helpers for the weight server.
// Saturating update arithmetic is selected with WEIGHT_SERVER_SAT_EN.
package nn_pkg;

    localparam int DEF_NUM_NEURONS = 128;
    localparam int DEF_IMG_SZ      = 784;
    localparam int DEF_OUTPUT_SZ   = 10;

    // 16.16 two's-complement fixed point
    typedef logic signed [31:0] word_t;

    typedef enum logic [1:0] {
        B_IDLE,
        B_READ,
        B_UPD
    } bank_state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic word_t sat_add(input word_t a, input word_t b);
        word_t s;
        s = a + b;
        if ((a[31] == b[31]) && (s[31] != a[31])) begin
            s = a[31] ? word_t'(32'h8000_0000) : word_t'(32'h7FFF_FFFF);
        end
        return s;
    endfunction

endpackage

// File: rtl/weight_bank.sv
// One weight bank: ROWS x COLS word storage, read/update stream FSM with row pointer,
// registered row output and a single-word host write. Saturation under WEIGHT_SERVER_SAT_EN.
module weight_bank
    import nn_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 3,
    parameter int RW   = clog2_min1(ROWS),
    parameter int CW   = clog2_min1(COLS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 get,
    input  logic                 upd,
    input  logic [COLS*32-1:0]   wchange,
    input  logic                 ld_en,
    input  logic [RW-1:0]        ld_row,
    input  logic [CW-1:0]        ld_col,
    input  logic [31:0]          ld_data,
    output logic [COLS*32-1:0]   row_out,
    output bank_state_t          state,
    output logic                 err_evt
);

    word_t              mem [ROWS][COLS];
    bank_state_t        state_q, state_d;
    logic [RW-1:0]      ptr_q, ptr_d, rd_idx;
    logic [COLS*32-1:0] row_q, row_d, rd_row;
    word_t              sum [COLS];
    logic               upd_we;
    logic               last;

    // Row fetched for the next presented cycle, and the per-word update result for ptr_q.
    always_comb begin
        last   = (ptr_q == RW'(ROWS - 1));
        rd_idx = (get || last) ? '0 : ptr_q + RW'(1);
        for (int c = 0; c < COLS; c++) begin
            rd_row[c*32 +: 32] = mem[rd_idx][c];
`ifdef WEIGHT_SERVER_SAT_EN
            sum[c] = sat_add(mem[ptr_q][c], word_t'(wchange[c*32 +: 32]));
`else
            sum[c] = mem[ptr_q][c] + word_t'(wchange[c*32 +: 32]);
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        row_d   = '0;
        upd_we  = 1'b0;
        err_evt = 1'b0;
        if (upd) begin
            // a new update stream wins over a simultaneous get and over any running stream
            state_d = B_UPD;
            ptr_d   = '0;
            err_evt = get || (state_q != B_IDLE);
        end else if (get) begin
            state_d = B_READ;
            ptr_d   = '0;
            row_d   = rd_row;
            err_evt = (state_q != B_IDLE);
        end else begin
            case (state_q)
                B_READ: begin
                    if (last) begin
                        state_d = B_IDLE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + RW'(1);
                        row_d = rd_row;
                    end
                end
                B_UPD: begin
                    upd_we = 1'b1;
                    if (last) begin
                        state_d = B_IDLE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= B_IDLE;
            ptr_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            row_q   <= row_d;
        end
    end

    // Storage keeps its contents through reset; host writes only land while idle.
    always_ff @(posedge clk) begin
        if (upd_we) begin
            for (int c = 0; c < COLS; c++) begin
                mem[ptr_q][c] <= sum[c];
            end
        end else if (ld_en) begin
            mem[ld_row][ld_col] <= ld_data;
        end
    end

    assign row_out = row_q;
    assign state   = state_q;

endmodule

// File: rtl/weight_server.sv
// Weight storage responder: two concurrent banks streaming rows to / accumulating deltas from
// the tile, plus a range-checked host load port. Saturating updates under WEIGHT_SERVER_SAT_EN.
module weight_server
    import nn_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int IMG_SZ      = DEF_IMG_SZ,
    parameter int OUTPUT_SZ   = DEF_OUTPUT_SZ
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          get_weights0,
    input  logic                          get_weights1,
    input  logic                          update0,
    input  logic                          update1,
    input  logic [NUM_NEURONS*32-1:0]     wchange0,
    input  logic [OUTPUT_SZ*32-1:0]       wchange1,
    output logic [NUM_NEURONS*32-1:0]     weights0,
    output logic [OUTPUT_SZ*32-1:0]       weights1,
    output logic                          busy0,
    output logic                          busy1,
    input  logic                          load_en,
    input  logic                          load_bank,
    input  logic [$clog2(IMG_SZ)-1:0]     load_row,
    input  logic [$clog2(NUM_NEURONS)-1:0] load_col,
    input  logic [31:0]                   load_data,
    output logic                          err
);

    localparam int R0W = clog2_min1(IMG_SZ);
    localparam int C0W = clog2_min1(NUM_NEURONS);
    localparam int R1W = clog2_min1(NUM_NEURONS);
    localparam int C1W = clog2_min1(OUTPUT_SZ);

    bank_state_t bank0_state, bank1_state;
    logic        bank0_err, bank1_err;
    logic        in0, in1, ld0_ok, ld1_ok, ld_rej;
    logic        err_q, err_d;

    assign busy0 = (bank0_state != B_IDLE);
    assign busy1 = (bank1_state != B_IDLE);

    // Bank 1 is the smaller array, so its address fields are the low bits of the shared port.
    always_comb begin
        in0    = (32'(load_row) < IMG_SZ)      && (32'(load_col) < NUM_NEURONS);
        in1    = (32'(load_row) < NUM_NEURONS) && (32'(load_col) < OUTPUT_SZ);
        ld0_ok = load_en && !load_bank && !busy0 && in0;
        ld1_ok = load_en &&  load_bank && !busy1 && in1;
        ld_rej = load_en && !(ld0_ok || ld1_ok);
        err_d  = ld_rej || bank0_err || bank1_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

    weight_bank #(
        .ROWS (IMG_SZ),
        .COLS (NUM_NEURONS)
    ) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .get     (get_weights0),
        .upd     (update0),
        .wchange (wchange0),
        .ld_en   (ld0_ok),
        .ld_row  (load_row[R0W-1:0]),
        .ld_col  (load_col[C0W-1:0]),
        .ld_data (load_data),
        .row_out (weights0),
        .state   (bank0_state),
        .err_evt (bank0_err)
    );

    weight_bank #(
        .ROWS (NUM_NEURONS),
        .COLS (OUTPUT_SZ)
    ) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .get     (get_weights1),
        .upd     (update1),
        .wchange (wchange1),
        .ld_en   (ld1_ok),
        .ld_row  (load_row[R1W-1:0]),
        .ld_col  (load_col[C1W-1:0]),
        .ld_data (load_data),
        .row_out (weights1),
        .state   (bank1_state),
        .err_evt (bank1_err)
    );

endmodule

// File: tb/tb_weight_server.sv
// Directed bench for weight_server with IMG_SZ=4, NUM_NEURONS=3, OUTPUT_SZ=2.
module tb_weight_server;

    localparam int NN = 3;
    localparam int IS = 4;
    localparam int OS = 2;

`ifdef WEIGHT_SERVER_SAT_EN
    localparam logic [31:0] OVF_EXP = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] OVF_EXP = 32'h8000_0010;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            get_weights0 = 1'b0;
    logic            get_weights1 = 1'b0;
    logic            update0 = 1'b0;
    logic            update1 = 1'b0;
    logic [NN*32-1:0] wchange0 = '0;
    logic [OS*32-1:0] wchange1 = '0;
    logic [NN*32-1:0] weights0;
    logic [OS*32-1:0] weights1;
    logic            busy0, busy1;
    logic            load_en = 1'b0;
    logic            load_bank = 1'b0;
    logic [1:0]      load_row = '0;
    logic [1:0]      load_col = '0;
    logic [31:0]     load_data = '0;
    logic            err;

    logic [63:0]     exp1 [3];
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    weight_server #(
        .NUM_NEURONS (NN),
        .IMG_SZ      (IS),
        .OUTPUT_SZ   (OS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .get_weights0 (get_weights0),
        .get_weights1 (get_weights1),
        .update0      (update0),
        .update1      (update1),
        .wchange0     (wchange0),
        .wchange1     (wchange1),
        .weights0     (weights0),
        .weights1     (weights1),
        .busy0        (busy0),
        .busy1        (busy1),
        .load_en      (load_en),
        .load_bank    (load_bank),
        .load_row     (load_row),
        .load_col     (load_col),
        .load_data    (load_data),
        .err          (err)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] row0_exp(input int k);
        return {32'(16*k + 2), 32'(16*k + 1), 32'(16*k)};
    endfunction

    task automatic load_word(input logic bank, input logic [1:0] row, input logic [1:0] col,
                             input logic [31:0] data);
        load_en   = 1'b1;
        load_bank = bank;
        load_row  = row;
        load_col  = col;
        load_data = data;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic stream0(input string tag);
        get_weights0 = 1'b1;
        tick();
        get_weights0 = 1'b0;
        for (int k = 0; k < IS; k++) begin
            check($sformatf("%s_row%0d", tag, k), weights0, row0_exp(k));
            check($sformatf("%s_busy%0d", tag, k), busy0, 1'b1);
            tick();
        end
        check($sformatf("%s_end_data", tag), weights0, '0);
        check($sformatf("%s_end_busy", tag), busy0, 1'b0);
    endtask

    task automatic stream1(input string tag);
        get_weights1 = 1'b1;
        tick();
        get_weights1 = 1'b0;
        for (int k = 0; k < NN; k++) begin
            check($sformatf("%s_row%0d", tag, k), weights1, exp1[k]);
            tick();
        end
        check($sformatf("%s_end_data", tag), weights1, '0);
        check($sformatf("%s_end_busy", tag), busy1, 1'b0);
    endtask

    task automatic update1_stream(input logic [63:0] delta);
        update1 = 1'b1;
        tick();
        update1  = 1'b0;
        wchange1 = delta;
        for (int k = 0; k < NN; k++) begin
            check("upd1_busy", busy1, 1'b1);
            tick();
        end
        wchange1 = '0;
        check("upd1_done", busy1, 1'b0);
        check("upd1_err", err, 1'b0);
    endtask

    initial begin
        // clock/reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_w0", weights0, '0);
        check("rst_w1", weights1, '0);
        check("rst_busy0", busy0, 1'b0);
        check("rst_busy1", busy1, 1'b0);
        check("rst_err", err, 1'b0);
        rst = 1'b0;
        tick();

        // host loads
        for (int r = 0; r < IS; r++) begin
            for (int c = 0; c < NN; c++) begin
                load_word(1'b0, 2'(r), 2'(c), 32'(16*r + c));
                check("load0_err", err, 1'b0);
            end
        end
        for (int r = 0; r < NN; r++) begin
            for (int c = 0; c < OS; c++) begin
                load_word(1'b1, 2'(r), 2'(c), 32'h0001_0000);
                check("load1_err", err, 1'b0);
            end
        end

        stream0("rd0");

        // 1.0 + 0.5 = 1.5 in word 1, 1.0 + (-1.0) = 0 in word 0
        update1_stream({32'h0000_8000, 32'hFFFF_0000});
        for (int k = 0; k < NN; k++) exp1[k] = {32'h0001_8000, 32'h0000_0000};
        stream1("rd1");

        // signed overflow on row 0 word 0
        load_word(1'b1, 2'd0, 2'd0, 32'h7FFF_FFF0);
        check("ovf_load_err", err, 1'b0);
        update1_stream({32'h0000_0000, 32'h0000_0020});
        exp1[0] = {32'h0001_8000, OVF_EXP};
        exp1[1] = {32'h0001_8000, 32'h0000_0020};
        exp1[2] = {32'h0001_8000, 32'h0000_0020};
        stream1("ovf");

        // restart of a running read stream
        get_weights0 = 1'b1;
        tick();
        get_weights0 = 1'b0;
        check("abort_r0", weights0, row0_exp(0));
        tick();
        check("abort_r1", weights0, row0_exp(1));
        check("abort_pre_err", err, 1'b0);
        get_weights0 = 1'b1;
        tick();
        get_weights0 = 1'b0;
        check("abort_restart_r0", weights0, row0_exp(0));
        check("abort_err", err, 1'b1);
        tick();
        check("abort_restart_r1", weights0, row0_exp(1));
        check("abort_err_once", err, 1'b0);
        tick();
        check("abort_restart_r2", weights0, row0_exp(2));
        tick();
        check("abort_restart_r3", weights0, row0_exp(3));
        check("abort_busy", busy0, 1'b1);
        tick();
        check("abort_end_data", weights0, '0);
        check("abort_end_busy", busy0, 1'b0);

        // rejected loads: bank busy, then column out of range
        get_weights1 = 1'b1;
        tick();
        get_weights1 = 1'b0;
        check("busy_load_busy1", busy1, 1'b1);
        load_word(1'b1, 2'd1, 2'd0, 32'hDEAD_BEEF);
        check("busy_load_err", err, 1'b1);
        check("busy_load_row1", weights1, exp1[1]);
        tick();
        check("busy_load_err_clr", err, 1'b0);
        tick();
        check("busy_load_idle", busy1, 1'b0);
        load_word(1'b1, 2'd0, 2'd2, 32'hDEAD_BEEF);
        check("range_load_err", err, 1'b1);
        tick();
        check("range_load_err_clr", err, 1'b0);
        stream1("noload");

        // get and update together: update wins, zero deltas leave bank 0 intact
        get_weights0 = 1'b1;
        update0      = 1'b1;
        tick();
        get_weights0 = 1'b0;
        update0      = 1'b0;
        check("coll_err", err, 1'b1);
        check("coll_data", weights0, '0);
        check("coll_busy", busy0, 1'b1);
        repeat (IS) tick();
        check("coll_done", busy0, 1'b0);

        // asynchronous reset in the middle of a read stream
        get_weights0 = 1'b1;
        tick();
        get_weights0 = 1'b0;
        check("rst_mid_r0", weights0, row0_exp(0));
        tick();
        check("rst_mid_r1", weights0, row0_exp(1));
        rst = 1'b1;
        #1;
        check("rst_mid_data", weights0, '0);
        check("rst_mid_busy", busy0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        stream0("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
